// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline constants: opcodes, bubble encoding, reset PC, forwarding
// selects and the IF/ID register control/payload types.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // addi x0,x0,0: OP-IMM with rs1=x0, so the hazard unit never stalls on it
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EM   = 2'b01,
    FWD_MW   = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    FD_HOLD  = 2'b00,
    FD_FLUSH = 2'b01,
    FD_LOAD  = 2'b10
  } fd_ctrl_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } fd_t;

endpackage

// File: rtl/rv32i_fd_reg.sv
// IF/ID pipeline register with hold/flush/load control and decode-field extraction.
module rv32i_fd_reg
  import rv32i_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  fd_ctrl_e    ctrl,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  output logic [31:0] fd_inst,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_pc4,
  output logic        fd_valid,
  output logic [6:0]  fd_op,
  output logic [4:0]  fd_rd,
  output logic [4:0]  fd_rs1,
  output logic [4:0]  fd_rs2
);

  fd_t fd_q, fd_d;

  always_comb begin
    fd_d = fd_q;
    unique case (ctrl)
      FD_FLUSH: fd_d = '{inst: NOP, pc: pc_in, valid: 1'b0};
      FD_LOAD:  fd_d = '{inst: inst_in, pc: pc_in, valid: 1'b1};
      default:  fd_d = fd_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fd_q <= '{inst: NOP, pc: 32'h0, valid: 1'b0};
    else     fd_q <= fd_d;
  end

  assign fd_inst  = fd_q.inst;
  assign fd_pc    = fd_q.pc;
  assign fd_pc4   = fd_q.pc + 32'd4;
  assign fd_valid = fd_q.valid;
  assign fd_op    = fd_q.inst[6:0];
  assign fd_rd    = fd_q.inst[11:7];
  assign fd_rs1   = fd_q.inst[19:15];
  assign fd_rs2   = fd_q.inst[24:20];

endmodule

// File: rtl/rv32i_if_stage.sv
// RV32I fetch stage: PC register, next-PC priority (redirect > stall > mem wait > fetch),
// IF/ID register and fetch/bubble performance counters.
module rv32i_if_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = rv32i_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] FD_inst,
  output logic [31:0] FD_pc,
  output logic [31:0] FD_pc4,
  output logic        FD_valid,
  output logic [6:0]  FD_OP,
  output logic [4:0]  FD_rd,
  output logic [4:0]  FD_rs1,
  output logic [4:0]  FD_rs2,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  fd_ctrl_e    fd_ctrl;

  always_comb begin
    pc_d         = pc_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    fd_ctrl      = FD_HOLD;
    // A redirect overrides stall: the FD instruction is wrong-path either way
    if (redirect) begin
      pc_d         = redirect_pc & ALIGN_MASK;
      fd_ctrl      = FD_FLUSH;
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else if (stall) begin
      fd_ctrl = FD_HOLD;
    end else if (!imem_ready) begin
      fd_ctrl      = FD_FLUSH;
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      pc_d        = pc_q + 32'd4;
      fd_ctrl     = FD_LOAD;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC & ALIGN_MASK;
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  rv32i_fd_reg #(.NOP(NOP_INST)) u_fd_reg (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (fd_ctrl),
    .inst_in  (imem_rdata),
    .pc_in    (pc_q),
    .fd_inst  (FD_inst),
    .fd_pc    (FD_pc),
    .fd_pc4   (FD_pc4),
    .fd_valid (FD_valid),
    .fd_op    (FD_OP),
    .fd_rd    (FD_rd),
    .fd_rs1   (FD_rs1),
    .fd_rs2   (FD_rs2)
  );

  assign imem_addr  = pc_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_rv32i_if_stage.sv
// Directed-vector bench for rv32i_if_stage; driver queues hand-computed expectations,
// a monitor pops and compares them on the falling edge.
module tb_rv32i_if_stage;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, redirect = 1'b0, imem_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic [31:0] imem_addr, FD_inst, FD_pc, FD_pc4, fetch_cnt, bubble_cnt;
  logic        FD_valid;
  logic [6:0]  FD_OP;
  logic [4:0]  FD_rd, FD_rs1, FD_rs2;

  rv32i_if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .FD_inst(FD_inst), .FD_pc(FD_pc), .FD_pc4(FD_pc4), .FD_valid(FD_valid),
    .FD_OP(FD_OP), .FD_rd(FD_rd), .FD_rs1(FD_rs1), .FD_rs2(FD_rs2),
    .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, inst, pc;
    logic        valid;
    logic [31:0] fcnt, bcnt;
  } exp_t;

  typedef struct {
    logic        stall, redirect, ready;
    logic [31:0] rpc, rdata;
    exp_t        e;
  } vec_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compares every queued expectation against the DUT on the falling edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_addr",  imem_addr,  e.addr);
      chk("FD_inst",    FD_inst,    e.inst);
      chk("FD_pc",      FD_pc,      e.pc);
      chk("FD_valid",   {31'b0, FD_valid}, {31'b0, e.valid});
      chk("fetch_cnt",  fetch_cnt,  e.fcnt);
      chk("bubble_cnt", bubble_cnt, e.bcnt);
      chk("FD_OP",      {25'b0, FD_OP},  {25'b0, e.inst[6:0]});
      chk("FD_rd",      {27'b0, FD_rd},  {27'b0, e.inst[11:7]});
      chk("FD_rs1",     {27'b0, FD_rs1}, {27'b0, e.inst[19:15]});
      chk("FD_rs2",     {27'b0, FD_rs2}, {27'b0, e.inst[24:20]});
      chk("FD_pc4",     FD_pc4,     e.pc + 32'd4);
    end
  end

  function automatic vec_t mk(input logic s, r, rdy, input logic [31:0] rpc, rdata,
                              input logic [31:0] a, i, p, input logic v,
                              input logic [31:0] f, b);
    vec_t t;
    t.stall = s; t.redirect = r; t.ready = rdy; t.rpc = rpc; t.rdata = rdata;
    t.e = '{addr: a, inst: i, pc: p, valid: v, fcnt: f, bcnt: b};
    return t;
  endfunction

  task automatic apply(input vec_t t);
    stall = t.stall; redirect = t.redirect; imem_ready = t.ready;
    redirect_pc = t.rpc; imem_rdata = t.rdata;
    @(posedge clk); #1;
    q.push_back(t.e);
    @(negedge clk); #1;
  endtask

  vec_t pre[$], post[$];

  initial begin
    // stall, redirect, ready, redirect_pc, rdata -> addr, inst, pc, valid, fetch, bubble
    pre.push_back(mk(0,0,1, 32'h0, 32'h00500093, 32'h4, 32'h00500093, 32'h0, 1, 1, 0));
    pre.push_back(mk(0,0,1, 32'h0, 32'h00208133, 32'h8, 32'h00208133, 32'h4, 1, 2, 0));

    post.push_back(mk(0,0,1, 32'h0, 32'h00500093, 32'h4,  32'h00500093, 32'h0, 1, 1, 0));
    post.push_back(mk(0,0,1, 32'h0, 32'h00a00113, 32'h8,  32'h00a00113, 32'h4, 1, 2, 0));
    post.push_back(mk(0,0,1, 32'h0, 32'h0000a183, 32'hc,  32'h0000a183, 32'h8, 1, 3, 0));
    // load-use stall for two cycles
    post.push_back(mk(1,0,1, 32'h0, 32'h003181b3, 32'hc,  32'h0000a183, 32'h8, 1, 3, 0));
    post.push_back(mk(1,0,1, 32'h0, 32'h003181b3, 32'hc,  32'h0000a183, 32'h8, 1, 3, 0));
    post.push_back(mk(0,0,1, 32'h0, 32'h003181b3, 32'h10, 32'h003181b3, 32'hc, 1, 4, 0));
    // redirect beats stall, low bits dropped
    post.push_back(mk(1,1,1, 32'h103, 32'hdeadbeef, 32'h100, 32'h13, 32'h10, 0, 4, 1));
    post.push_back(mk(0,0,1, 32'h0, 32'h00c00213, 32'h104, 32'h00c00213, 32'h100, 1, 5, 1));
    // memory wait at 0x20
    post.push_back(mk(0,1,1, 32'h20, 32'h0, 32'h20, 32'h13, 32'h104, 0, 5, 2));
    post.push_back(mk(0,0,0, 32'h0, 32'hdeadbeef, 32'h20, 32'h13, 32'h20, 0, 5, 3));
    post.push_back(mk(0,0,0, 32'h0, 32'hdeadbeef, 32'h20, 32'h13, 32'h20, 0, 5, 4));
    post.push_back(mk(0,0,0, 32'h0, 32'hdeadbeef, 32'h20, 32'h13, 32'h20, 0, 5, 5));
    post.push_back(mk(0,0,1, 32'h0, 32'h00128293, 32'h24, 32'h00128293, 32'h20, 1, 6, 5));
    // PC wrap
    post.push_back(mk(0,1,0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 32'h13, 32'h24, 0, 6, 6));
    post.push_back(mk(0,0,1, 32'h0, 32'h00100513, 32'h0, 32'h00100513, 32'hFFFFFFFC, 1, 7, 6));
    // stall dominates a not-ready memory
    post.push_back(mk(1,0,0, 32'h0, 32'h0, 32'h0, 32'h00100513, 32'hFFFFFFFC, 1, 7, 6));

    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    foreach (pre[i]) apply(pre[i]);

    // asynchronous reset mid-cycle: state must clear before any edge
    @(posedge clk); #2;
    rst = 1'b1; #1;
    q.push_back('{addr: 32'h0, inst: 32'h13, pc: 32'h0, valid: 1'b0, fcnt: 32'h0, bcnt: 32'h0});
    @(negedge clk); #1;
    rst = 1'b0;

    foreach (post[i]) apply(post[i]);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32i_if_stage.md
# rv32i_if_stage

Instruction-fetch stage of the RV32I 5-stage pipeline: PC register, next-PC selection, instruction-memory request and the IF/ID (FD) pipeline register. It sits directly upstream of the hazard/stall unit. It produces the `FD_OP`/`FD_rs1`/`FD_rs2` fields that unit decodes, and consumes its `stall` output to freeze fetch during load-use and JALR hazards. It also accepts taken-branch/jump redirects and inserts bubbles, and keeps two 32-bit performance counters.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded by reset.
- `NOP_INST`, default `32'h0000_0013`: bubble encoding (`addi x0,x0,0`).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `stall` in 1: from hazard unit; hold PC and the FD register.
- `redirect` in 1: taken branch/JAL/JALR resolved downstream.
- `redirect_pc` in 32: target address for a redirect.
- `imem_rdata` in 32: instruction at `imem_addr`, combinational read.
- `imem_ready` in 1: `imem_rdata` is valid this cycle.
- `imem_addr` out 32: current PC.
- `FD_inst` out 32: instruction in ID.
- `FD_pc` out 32: PC of `FD_inst`.
- `FD_pc4` out 32: `FD_pc + 4`.
- `FD_valid` out 1: `FD_inst` is a real fetched instruction, not a bubble.
- `FD_OP` out 7: `FD_inst[6:0]`.
- `FD_rd` out 5: `FD_inst[11:7]`.
- `FD_rs1` out 5: `FD_inst[19:15]`.
- `FD_rs2` out 5: `FD_inst[24:20]`.
- `fetch_cnt` out 32: number of instructions accepted into FD.
- `bubble_cnt` out 32: number of bubbles inserted into FD.

## Operation
- Registers:
  - `pc`: reset value `RESET_PC`.
  - FD register: `FD_inst=NOP_INST`, `FD_pc=0`, `FD_valid=0` on reset.
  - Counters: 0 on reset.
  - `imem_addr = pc` (combinational). `FD_OP`, `FD_rd`, `FD_rs1`, `FD_rs2` and `FD_pc4` are combinational from the FD register.
- Per-edge priority:
  - **`rst`**: asynchronous reset to the values above.
  - **`redirect`**: `pc <= {redirect_pc[31:2],2'b00}`, FD <= bubble, `bubble_cnt++`. This applies regardless of `stall` or `imem_ready`. The flushed FD instruction is wrong-path, so discarding it during a stall is correct.
  - **`stall`**: `pc` and the FD register hold; no counter changes.
  - **`!imem_ready`**: `pc` holds, FD <= bubble, `bubble_cnt++`.
  - **Otherwise**: `FD_inst <= imem_rdata`, `FD_pc <= pc`, `FD_valid <= 1`, `pc <= pc + 4`, `fetch_cnt++`.
- A bubble sets `FD_inst=NOP_INST`, `FD_valid=0` and `FD_pc=pc`. `NOP_INST` decodes as OP-IMM with `rs1=0`, so the hazard unit never stalls on a bubble.
- Arithmetic:
  - `pc + 4` wraps modulo 2^32, so `32'hFFFF_FFFC` is followed by `32'h0000_0000`.
  - Counters wrap modulo 2^32 with no saturation.
- `pc[1:0]` is always `2'b00`. Redirect bits `[1:0]` are discarded.
- Reset mid-stall or mid-redirect: reset wins immediately and asynchronously. The first edge after release fetches from `RESET_PC`.

## Timing
- Fetch latency is 1 cycle: the instruction at `pc` is presented on `FD_inst` after the next rising edge.
- The hazard unit sees `FD_*` for a full cycle. `stall` is combinational from `FD_*`/`DE_*` and sampled here on the same edge, so hold takes effect on that edge.
- Redirect penalty: a redirect asserted in cycle N gives FD = bubble after edge N. The target instruction appears in FD after edge N+1.
- With `stall` held for k cycles, `FD_inst` and `pc` stay constant for k edges. Fetch resumes on the first edge with `stall=0`.
- There is no combinational path from any input to any output except `imem_addr`, which depends only on `pc`.

## Structure
- Shared package `rv32i_pkg` holds:
  - the opcode constants `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_IMM`, `OP_OP`;
  - `NOP_INST`;
  - `RESET_PC` default;
  - the `forward` encodings (`FWD_NONE=2'b00`, `FWD_EM=2'b01`, `FWD_MW=2'b10`).
  The hazard unit is expected to migrate to these constants.
- One sub-module: `rv32i_fd_reg`, the FD pipeline register with hold/flush/load controls and field extraction.
- The PC/next-PC logic and counters stay in the top level.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle. Required: `imem_addr=RESET_PC`, `FD_inst=32'h13`, `FD_valid=0` and counters 0 immediately. After release, 3 ready edges give `FD_pc=8` and `fetch_cnt=3`.
- **Straight line:** `imem_ready=1` with `imem_rdata=32'h00500093` at `pc=0`. Required after one edge: `FD_OP=7'b0010011`, `FD_rd=1`, `FD_rs1=0`, `FD_pc4=4`, `pc=4`.
- **Load-use stall:** `stall=1` for 2 cycles while `FD_pc=8`. Required: `FD_pc=8`, `FD_inst` and `imem_addr=12` unchanged, `fetch_cnt` unchanged. Next edge `FD_pc=12`.
- **Redirect with stall:** `redirect=1`, `stall=1`, `redirect_pc=32'h0000_0103`. Required: `pc=32'h100`, `FD_valid=0`, `bubble_cnt+1`. Next edge `FD_pc=32'h100`.
- **Memory wait:** `imem_ready=0` for 3 cycles at `pc=32'h20`. Required: 3 bubbles, `bubble_cnt+3`, `pc` held at `32'h20`. Then fetch `FD_pc=32'h20`.
- **PC wrap:** `redirect_pc=32'hFFFF_FFFC`, then one ready edge. Required: `FD_pc=32'hFFFF_FFFC`, `FD_pc4=0`, `pc=0`.
